perf_counter_bank: RTL

PERF_COUNTER_BANK -- requirements
Module: perf_counter_bank

---
 rtl/perf_counter_bank.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/perf_counter_bank.sv
// -----------------------------------------------------------------------------
// perf_counter_bank
//   A bank of per-channel performance counters. Each channel has two counters
//   that run for the life of the block: one for events and one for misses. Both
//   saturate at all-ones. Each channel also has a pair of window accumulators.
//   When a window of 2^WIN_W enabled cycles closes, the accumulators are copied
//   to the win_* outputs. The window timer and all counting pause while en is
//   low.
//
// Ports
//   clk        in   1                  clock, rising edge
//   rst_n      in   1                  asynchronous reset, active low
//   en         in   1                  counting / window-timer enable
//   clr        in   1                  synchronous clear, wins over events
//   evt_valid  in   NUM_CH             event occurred on channel i
//   evt_miss   in   NUM_CH             that event was a miss (needs evt_valid)
//   total_cnt  out  NUM_CH*CNT_W       lifetime event counts, ch i at [i*CNT_W +: CNT_W]
//   miss_cnt   out  NUM_CH*CNT_W       lifetime miss counts, same packing
//   win_total  out  NUM_CH*(WIN_W+1)   event count of last completed window
//   win_miss   out  NUM_CH*(WIN_W+1)   miss count of last completed window
//   win_valid  out  1                  one-cycle pulse when win_* update
//   sat        out  NUM_CH             sticky: a lifetime counter saturated
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | en low; counters and window timer hold
// RUN   | en high; events count, window timer advances
// -----------------------------------------------------------------------------
module perf_counter_bank #(
   parameter int NUM_CH = 4,
   parameter int CNT_W  = 32,
   parameter int WIN_W  = 10
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          en,
   input  logic                          clr,
   input  logic [NUM_CH-1:0]             evt_valid,
   input  logic [NUM_CH-1:0]             evt_miss,
   output logic [NUM_CH*CNT_W-1:0]       total_cnt,
   output logic [NUM_CH*CNT_W-1:0]       miss_cnt,
   output logic [NUM_CH*(WIN_W+1)-1:0]   win_total,
   output logic [NUM_CH*(WIN_W+1)-1:0]   win_miss,
   output logic                          win_valid,
   output logic [NUM_CH-1:0]             sat
);

   localparam int AW = WIN_W + 1;

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_RUN  = 1'b1;

   logic [0:0]       r_state;
   logic [0:0]       w_state_nxt;
   logic [WIN_W-1:0] r_timer;
   logic             r_win_valid;
   logic             w_cnt_en;
   logic             w_win_end;

   logic [NUM_CH-1:0] w_inc_t;
   logic [NUM_CH-1:0] w_inc_m;

   always_comb begin
      w_state_nxt = r_state;
      if (clr) begin
         w_state_nxt = ST_IDLE;
      end else begin
         case (r_state)
            ST_IDLE: if (en)  w_state_nxt = ST_RUN;
            ST_RUN:  if (!en) w_state_nxt = ST_IDLE;
            default:          w_state_nxt = ST_IDLE;
         endcase
      end
   end

   // Counting is active in exactly the cycles that lead into RUN. The same-cycle
   // en therefore counts with no extra cycle of latency on entering RUN. A clr
   // also forces this low, so the events of a clr cycle are dropped.
   assign w_cnt_en  = (w_state_nxt == ST_RUN);
   assign w_win_end = w_cnt_en && (r_timer == {WIN_W{1'b1}});

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= ST_IDLE;
         r_timer     <= '0;
         r_win_valid <= 1'b0;
      end else if (clr) begin
         r_state     <= ST_IDLE;
         r_timer     <= '0;
         r_win_valid <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_win_valid <= w_win_end;
         if (w_cnt_en) begin
            r_timer <= r_timer + WIN_W'(1);
         end
      end
   end

   assign win_valid = r_win_valid;

   genvar g;
   generate
      for (g = 0; g < NUM_CH; g++) begin : g_ch
         logic [CNT_W-1:0] r_total;
         logic [CNT_W-1:0] r_miss;
         logic [AW-1:0]    r_acc_t;
         logic [AW-1:0]    r_acc_m;
         logic [AW-1:0]    r_win_t;
         logic [AW-1:0]    r_win_m;
         logic             r_sat;

         assign w_inc_t[g] = w_cnt_en & evt_valid[g];
         assign w_inc_m[g] = w_inc_t[g] & evt_miss[g];

         // A miss is always also an event, and both counters saturate at the
         // same value. So miss never passes total, even once total is pinned.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               r_total <= '0;
               r_miss  <= '0;
               r_acc_t <= '0;
               r_acc_m <= '0;
               r_win_t <= '0;
               r_win_m <= '0;
               r_sat   <= 1'b0;
            end else if (clr) begin
               r_total <= '0;
               r_miss  <= '0;
               r_acc_t <= '0;
               r_acc_m <= '0;
               r_win_t <= '0;
               r_win_m <= '0;
               r_sat   <= 1'b0;
            end else begin
               if (w_inc_t[g]) begin
                  if (r_total == {CNT_W{1'b1}}) r_sat   <= 1'b1;
                  else                          r_total <= r_total + CNT_W'(1);
               end
               if (w_inc_m[g]) begin
                  if (r_miss == {CNT_W{1'b1}})  r_sat   <= 1'b1;
                  else                          r_miss  <= r_miss + CNT_W'(1);
               end
               // The closing cycle's own events belong to the window being
               // published, so they are added on the way out rather than lost.
               if (w_win_end) begin
                  r_win_t <= r_acc_t + AW'(w_inc_t[g]);
                  r_win_m <= r_acc_m + AW'(w_inc_m[g]);
                  r_acc_t <= '0;
                  r_acc_m <= '0;
               end else begin
                  r_acc_t <= r_acc_t + AW'(w_inc_t[g]);
                  r_acc_m <= r_acc_m + AW'(w_inc_m[g]);
               end
            end
         end

         assign total_cnt[g*CNT_W +: CNT_W] = r_total;
         assign miss_cnt [g*CNT_W +: CNT_W] = r_miss;
         assign win_total[g*AW +: AW]       = r_win_t;
         assign win_miss [g*AW +: AW]       = r_win_m;
         assign sat[g]                      = r_sat;
      end
   endgenerate

endmodule
